// File: rtl/audio_avg_filter_if.sv
// Codec read/write handshake bundle between the audio codec and the filter.
// master = filter side, slave = codec side.
interface audio_avg_filter_if #(
  parameter int DATA_W = 24
);
  logic              read_ready;
  logic [DATA_W-1:0] readdata_left;
  logic [DATA_W-1:0] readdata_right;
  logic              read;
  logic              write_ready;
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;

  modport master (
    input  read_ready,
    input  readdata_left,
    input  readdata_right,
    output read,
    input  write_ready,
    output write,
    output writedata_left,
    output writedata_right
  );

  modport slave (
    output read_ready,
    output readdata_left,
    output readdata_right,
    input  read,
    output write_ready,
    input  write,
    input  writedata_left,
    input  writedata_right
  );
endinterface

// File: rtl/audio_avg_filter.sv
// Stereo N-tap moving-average filter between codec read and write sides.
// Optional AVG_FILTER_BYPASS_EN adds a bypass input that passes raw samples.
module audio_avg_filter #(
  parameter int DATA_W    = 24,
  parameter int LOG2_TAPS = 3
) (
  input  logic CLOCK_50,
  input  logic resetn,
`ifdef AVG_FILTER_BYPASS_EN
  input  logic bypass,
`endif
  audio_avg_filter_if.master cdc
);
  localparam int N  = 1 << LOG2_TAPS;
  localparam int SW = DATA_W + LOG2_TAPS;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    WAIT_WR
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_read;
  logic   w_write;
  logic   w_byp;

  logic signed [DATA_W-1:0] r_in_l;
  logic signed [DATA_W-1:0] r_in_r;
  logic signed [DATA_W-1:0] r_wd_l;
  logic signed [DATA_W-1:0] r_wd_r;
  logic signed [DATA_W-1:0] r_buf_l [N];
  logic signed [DATA_W-1:0] r_buf_r [N];
  logic [LOG2_TAPS-1:0]     r_ptr;

  logic signed [SW-1:0]     r_sum_l;
  logic signed [SW-1:0]     r_sum_r;
  logic signed [SW-1:0]     w_sum_l;
  logic signed [SW-1:0]     w_sum_r;
  logic signed [DATA_W-1:0] w_out_l;
  logic signed [DATA_W-1:0] w_out_r;

  function automatic logic signed [SW-1:0] sext(
    input logic [DATA_W-1:0] x
  );
    return {{LOG2_TAPS{x[DATA_W-1]}}, x};
  endfunction

`ifdef AVG_FILTER_BYPASS_EN
  assign w_byp = bypass;
`else
  assign w_byp = 1'b0;
`endif

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (cdc.read_ready)  w_next = UPDATE;
      UPDATE:                       w_next = WAIT_WR;
      WAIT_WR: if (cdc.write_ready) w_next = IDLE;
      default:                      w_next = IDLE;
    endcase
  end

  // Strobes; gated by reset so nothing is popped or pushed while clearing
  always_comb begin
    w_read  = 1'b0;
    w_write = 1'b0;
    if (resetn) begin
      w_read  = (r_state == IDLE)    && cdc.read_ready;
      w_write = (r_state == WAIT_WR) && cdc.write_ready;
    end
  end

  // Running sums after replacing the oldest sample; the top DATA_W bits
  // are the arithmetic shift by LOG2_TAPS, i.e. floor of the average
  always_comb begin
    w_sum_l = r_sum_l + sext(r_in_l) - sext(r_buf_l[r_ptr]);
    w_sum_r = r_sum_r + sext(r_in_r) - sext(r_buf_r[r_ptr]);
    w_out_l = w_byp ? r_in_l : w_sum_l[SW-1:LOG2_TAPS];
    w_out_r = w_byp ? r_in_r : w_sum_r[SW-1:LOG2_TAPS];
  end

  // Capture the sample pair on the pop strobe
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_in_l <= '0;
      r_in_r <= '0;
    end else if (w_read) begin
      r_in_l <= cdc.readdata_left;
      r_in_r <= cdc.readdata_right;
    end
  end

  // Delay lines, sums and pointer advance once per sample in UPDATE
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_sum_l <= '0;
      r_sum_r <= '0;
      r_ptr   <= '0;
      for (int i = 0; i < N; i++) begin
        r_buf_l[i] <= '0;
        r_buf_r[i] <= '0;
      end
    end else if (r_state == UPDATE) begin
      r_sum_l        <= w_sum_l;
      r_sum_r        <= w_sum_r;
      r_buf_l[r_ptr] <= r_in_l;
      r_buf_r[r_ptr] <= r_in_r;
      r_ptr          <= r_ptr + 1'b1;
    end
  end

  // Output registers load on the way into WAIT_WR and hold otherwise
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_wd_l <= '0;
      r_wd_r <= '0;
    end else if (r_state == UPDATE) begin
      r_wd_l <= w_out_l;
      r_wd_r <= w_out_r;
    end
  end

  assign cdc.read            = w_read;
  assign cdc.write           = w_write;
  assign cdc.writedata_left  = r_wd_l;
  assign cdc.writedata_right = r_wd_r;
endmodule

// File: tb/tb_audio_avg_filter.sv
// Testbench for audio_avg_filter: vector table plus scoreboard queue.
// Define AVG_FILTER_BYPASS_EN to also exercise the bypass input.
module tb_audio_avg_filter;
  typedef struct {
    bit          rst;
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  logic clk = 1'b0;
  logic resetn;
`ifdef AVG_FILTER_BYPASS_EN
  logic bypass;
`endif

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    last_rd = 0;
  bit    prev_rd = 0;
  bit    prev_wr = 0;
  bit    lat_chk = 0;
  pair_t exp_q[$];
  vec_t  tbl[$];

  audio_avg_filter_if #(.DATA_W(24)) bus ();

  audio_avg_filter #(
    .DATA_W   (24),
    .LOG2_TAPS(3)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
`ifdef AVG_FILTER_BYPASS_EN
    .bypass  (bypass),
`endif
    .cdc     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [23:0] act, logic [23:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Codec-side monitor: strobe rules, latency, scoreboard pop
  always @(negedge clk) begin
    pair_t e;
    cyc++;
    if (bus.read || bus.write)
      chk("rd_wr_excl", 24'(bus.read & bus.write), 24'd0);
    if (bus.read) begin
      chk("rd_double", 24'(prev_rd), 24'd0);
      last_rd = cyc;
    end
    if (bus.write) begin
      chk("wr_double", 24'(prev_wr), 24'd0);
      if (lat_chk) chk("rd_wr_gap", 24'(cyc - last_rd), 24'd2);
      if (exp_q.size() == 0) begin
        chk("wr_expected", 24'(exp_q.size()), 24'd1);
      end else begin
        e = exp_q.pop_front();
        chk("out_l", bus.writedata_left, e.l);
        chk("out_r", bus.writedata_right, e.r);
      end
    end
    prev_rd = bus.read;
    prev_wr = bus.write;
  end

  task automatic add(bit rst, logic [23:0] l, logic [23:0] r,
                     logic [23:0] el, logic [23:0] er);
    vec_t v;
    v.rst = rst; v.l = l; v.r = r; v.el = el; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic send(logic [23:0] l, logic [23:0] r,
                      logic [23:0] el, logic [23:0] er, bit push);
    pair_t e;
    bit got = 0;
    if (push) begin
      e.l = el; e.r = er;
      exp_q.push_back(e);
    end
    bus.readdata_left  = l;
    bus.readdata_right = r;
    bus.read_ready     = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.read) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("read_timeout", 24'(got), 24'd1);
    @(posedge clk); #1;
    bus.read_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 24'(exp_q.size()), 24'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("rst_read", 24'(bus.read), 24'd0);
    chk("rst_write", 24'(bus.write), 24'd0);
    chk("rst_wd_l", bus.writedata_left, 24'd0);
    chk("rst_wd_r", bus.writedata_right, 24'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=done", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] held;
    int bp_bad;
    resetn             = 1'b0;
    bus.read_ready     = 1'b0;
    bus.readdata_left  = '0;
    bus.readdata_right = '0;
    bus.write_ready    = 1'b1;
`ifdef AVG_FILTER_BYPASS_EN
    bypass = 1'b0;
`endif

    // Impulse on left
    add(1, 24'h000800, 24'h0, 24'h000100, 24'h0);
    for (int k = 2; k <= 8; k++) add(0, 24'h0, 24'h0, 24'h000100, 24'h0);
    for (int k = 9; k <= 10; k++) add(0, 24'h0, 24'h0, 24'h0, 24'h0);
    // Full-scale DC ramp on left
    for (int k = 1; k <= 10; k++) begin
      longint v;
      v = (k >= 8) ? 64'h7FFFFF : (longint'(k) * 64'h7FFFFF) / 8;
      add(k == 1, 24'h7FFFFF, 24'h0, 24'(v), 24'h0);
    end
    // Negative impulse -8 on right
    add(1, 24'h0, 24'hFFFFF8, 24'h0, 24'hFFFFFF);
    for (int k = 2; k <= 8; k++) add(0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF);
    add(0, 24'h0, 24'h0, 24'h0, 24'h0);
    // Single -1 on right floors to -1
    add(1, 24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF);
    for (int k = 2; k <= 8; k++) add(0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF);
    add(0, 24'h0, 24'h0, 24'h0, 24'h0);

    do_reset();
    lat_chk = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        drain();
        do_reset();
      end
      send(tbl[i].l, tbl[i].r, tbl[i].el, tbl[i].er, 1);
    end
    drain();

    // Backpressure: 50 cycles with write_ready low, next pair waiting
    do_reset();
    lat_chk = 0;
    bus.write_ready = 1'b0;
    send(24'h000800, 24'h000010, 24'h000100, 24'h000002, 1);
    fork
      send(24'h0, 24'h0, 24'h000100, 24'h000002, 1);
      begin
        @(negedge clk);
        @(negedge clk);
        held = bus.writedata_left;
        bp_bad = 0;
        repeat (50) begin
          @(negedge clk);
          if (bus.read || bus.write || bus.writedata_left !== held)
            bp_bad++;
        end
        chk("bp_hold", 24'(bp_bad), 24'd0);
        chk("bp_value", held, 24'h000100);
        @(posedge clk); #1;
        bus.write_ready = 1'b1;
      end
    join
    drain();
    lat_chk = 1;

    // Reset while in WAIT_WR after the fourth sample
    do_reset();
    send(24'h000800, 24'h0, 24'h000100, 24'h0, 1);
    send(24'h000800, 24'h0, 24'h000200, 24'h0, 1);
    send(24'h000800, 24'h0, 24'h000300, 24'h0, 1);
    drain();
    bus.write_ready = 1'b0;
    send(24'h000800, 24'h0, 24'h0, 24'h0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    bus.write_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_read", 24'(bus.read), 24'd0);
    chk("mid_rst_write", 24'(bus.write), 24'd0);
    chk("mid_rst_wd_l", bus.writedata_left, 24'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    send(24'h000800, 24'h0, 24'h000100, 24'h0, 1);
    drain();

`ifdef AVG_FILTER_BYPASS_EN
    // Bypass passes raw input while the delay line keeps filling
    do_reset();
    bypass = 1'b1;
    send(24'h123456, 24'h0, 24'h123456, 24'h0, 1);
    drain();
    bypass = 1'b0;
    send(24'h0, 24'h0, 24'h02468A, 24'h0, 1);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_avg_filter.md
Name: audio_avg_filter

Overview:
- Moving-average noise filter between the audio_codec read side and write side.
- Consumes left/right ADC samples via the codec read handshake, averages each channel over the last N samples, and writes the results back via the codec write handshake.
- Replaces the direct readdata→writedata passthrough in the top level. One sample pair in, one pair out.

Parameters:
- DATA_W, 24, sample width per channel, signed two's complement
- LOG2_TAPS, 3, log2 of tap count; N = 2**LOG2_TAPS; legal range 1..4

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge
- resetn  input  1  synchronous reset, active-low; sampled on CLOCK_50 rising edge
- read_ready  input  1  codec has a sample pair available
- readdata_left  input  DATA_W  codec left sample; valid while read_ready=1
- readdata_right  input  DATA_W  codec right sample; valid while read_ready=1
- read  output  1  one-cycle pop strobe to codec
- write_ready  input  1  codec can accept a sample pair
- write  output  1  one-cycle push strobe to codec
- writedata_left  output  DATA_W  filtered left sample; registered
- writedata_right  output  DATA_W  filtered right sample; registered

Behaviour:
- Reset (resetn=0 at a clock edge):
  - read=0, write=0, writedata_left/right=0.
  - Both delay lines (N×DATA_W each) cleared to 0.
  - Both running sums cleared to 0; buffer pointer cleared to 0; FSM goes to IDLE.
- FSM states: IDLE, UPDATE, WAIT_WR.
- IDLE:
  - If read_ready=1: assert read for exactly one cycle, capture readdata_left/right into input registers in the same cycle, go to UPDATE.
  - Otherwise stay.
  - write_ready is ignored in IDLE.
- UPDATE (1 cycle), per channel:
  - sum <= sum + sext(new) - sext(buf[ptr]); buf[ptr] <= new.
  - ptr <= ptr+1, wrapping from N-1 to 0.
  - Go to WAIT_WR.
- WAIT_WR:
  - writedata_x = (updated sum) >>> LOG2_TAPS, arithmetic shift (floor toward -inf), truncated to DATA_W. This value is stable from the first WAIT_WR cycle.
  - If write_ready=1: assert write for exactly one cycle, go to IDLE.
  - Otherwise hold; writedata is held and no read is issued.
- Sum width: DATA_W+LOG2_TAPS, signed. Cannot overflow; the average always fits DATA_W.
- Strobes:
  - read and write are never high in the same cycle.
  - Each strobe is never high for 2 consecutive cycles.
  - Exactly one write per read.
- Latency: read strobe cycle → earliest write strobe is 2 cycles later (read in cycle t, UPDATE in t+1, write in t+2 if write_ready=1).
- Back-to-back throughput: one sample pair per 3 cycles minimum. This is far above the 48 kHz codec rate.
- Backpressure: write_ready=0 indefinitely keeps the FSM in WAIT_WR. Incoming samples accumulate in the codec FIFO and are not popped.
- resetn=0 in any state (including mid-UPDATE or WAIT_WR): abort, no further strobe, full clear as above. The pending sample is discarded.
- writedata_x is retained across IDLE/UPDATE until the next WAIT_WR update.

Optional Feature:
- Macro: AVG_FILTER_BYPASS_EN.
- When defined:
  - Adds port `bypass  input  1`.
  - While bypass=1, WAIT_WR presents the captured raw input samples instead of the average.
  - Delay lines and sums still update every sample, so deasserting bypass yields a correct average immediately.
  - bypass is sampled on entry to WAIT_WR.
- When undefined: no bypass port; output is always the average.

Test Plan:
1. Impulse (LOG2_TAPS=3): left 0x000800, then 9 samples of 0; right held 0; write_ready=1.
   → left outputs 0x000100 ×8, then 0x000000; right always 0x000000; read→write spacing exactly 2 cycles.
2. DC ramp: left 0x7FFFFF for 10 samples.
   → k-th output = floor(k·0x7FFFFF/8) for k=1..7; output 0x7FFFFF from the 8th sample on; no wrap or sign flip.
3. Negative floor: right single sample 0xFFFFF8 (-8), then zeros.
   → 0xFFFFFF (-1) ×8, then 0x000000.
   → Single sample 0xFFFFFF (-1): 0xFFFFFF ×8 (floor), then 0.
4. Backpressure: hold write_ready=0 for 50 cycles after a read while read_ready=1.
   → write=0 and read=0 throughout, writedata stable.
   → Raising write_ready gives one write pulse, then the next read.
5. Reset mid-operation: drive resetn=0 during WAIT_WR after 4 samples of 0x000800.
   → read=write=0, outputs 0.
   → Next sample 0x000800 yields output 0x000100, proving buffer and sum were cleared.
6. With AVG_FILTER_BYPASS_EN, bypass=1, input left 0x123456.
   → Output 0x123456.
   → Then bypass=0 with further inputs of 0: output = floor(0x123456/8) = 0x02468A, confirming the delay line kept updating.
